// File: rtl/reset_button_debounce.sv
// Purpose: turns the raw board reset pushbutton into a clean, fixed-width
//   active-high reset request for the power-on reset generator; also pulses
//   once after its own reset is released.
// Latency: btn_level follows a press DEBOUNCE_CYCLES+2 edges after the pin
//   changes, and reset_req rises one edge after that.
// Backpressure: none; reset_req is a fire-and-forget pulse of PULSE_CYCLES.
//
// Ports:
//   clk       - single clock, all state lives here
//   reset_n   - asynchronous active-low reset (forces a reset_req pulse)
//   btn_in    - raw, asynchronous, bouncing pushbutton pin
//   reset_req - registered active-high reset request pulse
//   btn_level - registered debounced press level (1 = pressed)
`timescale 1ns/1ps

module reset_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PULSE_CYCLES    = 16,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic reset_req,
  output logic btn_level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(PULSE_CYCLES - 1);
  // Pin level when the button is not pressed.
  localparam logic PIN_RELEASED = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  logic          sync_q1;
  logic          sync_q2;
  logic          btn_sync;
  logic [CW-1:0] cnt;
  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_nxt;

  // Two-flop synchronizer; resets to the released pin level so a reset
  // never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= PIN_RELEASED;
      sync_q2 <= PIN_RELEASED;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
    end
  end

  // Normalize polarity: 1 means pressed.
  assign btn_sync = BTN_ACTIVE_LOW ? ~sync_q2 : sync_q2;

  // Consecutive-sample debounce: any agreeing sample restarts the count,
  // so a level change needs DEBOUNCE_CYCLES differing samples in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_level <= 1'b0;
      cnt       <= '0;
    end else if (btn_sync == btn_level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      btn_level <= btn_sync;
      cnt       <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pulse FSM: one pulse per debounced press; HOLD swallows a held button.
  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    unique case (state)
      IDLE: begin
        if (btn_level) begin
          state_nxt = PULSE;
          pcnt_nxt  = '0;
        end
      end
      PULSE: begin
        if (pcnt == PCNT_LAST) begin
          state_nxt = btn_level ? HOLD : IDLE;
          pcnt_nxt  = '0;
        end else begin
          pcnt_nxt = pcnt + 1'b1;
        end
      end
      HOLD: begin
        if (!btn_level) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        pcnt_nxt  = '0;
      end
    endcase
  end

  // Reset parks the FSM in PULSE so a full pulse follows reset release.
  // reset_req is registered from the next state so it tracks PULSE exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PULSE;
      pcnt      <= '0;
      reset_req <= 1'b1;
    end else begin
      state     <= state_nxt;
      pcnt      <= pcnt_nxt;
      reset_req <= (state_nxt == PULSE);
    end
  end

endmodule

// File: tb/tb_reset_button_debounce.sv
`timescale 1ns/1ps

module tb_reset_button_debounce;

  localparam int DC = 4;
  localparam int PC = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic btn_in;
  logic reset_req;
  logic btn_level;

  int cyc = 0;        // number of rising edges seen so far
  int n_checks = 0;
  int n_fail = 0;
  bit done = 1'b0;

  typedef struct {
    bit val;
    int cyc;
  } ev_t;

  ev_t q_req[$];
  ev_t q_lvl[$];
  bit  prev_req = 1'b1;
  bit  prev_lvl = 1'b0;

  reset_button_debounce #(
    .DEBOUNCE_CYCLES(DC),
    .PULSE_CYCLES   (PC),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_in   (btn_in),
    .reset_req(reset_req),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Advance n rising edges, then settle 2ns past the edge before driving.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic exp_req(input bit v, input int c);
    ev_t e;
    e.val = v;
    e.cyc = c;
    q_req.push_back(e);
  endtask

  task automatic exp_lvl(input bit v, input int c);
    ev_t e;
    e.val = v;
    e.cyc = c;
    q_lvl.push_back(e);
  endtask

  // Stimulus: edge numbers below are the cyc value at which each output
  // change is expected (change happens on that edge, or asynchronously
  // just after it for reset assertion).
  initial begin
    btn_in  = 1'b1;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;

    // Power-up: reset for 5 edges; release at cyc 5, pulse ends at edge 8.
    tick(5);
    reset_n = 1'b1;
    exp_req(1'b0, 8);
    tick(10);                       // cyc 15

    // Clean press at 15: level 21, pulse 22..24, low from 25; held 30.
    btn_in = 1'b0;
    exp_lvl(1'b1, 21);
    exp_req(1'b1, 22);
    exp_req(1'b0, 25);
    tick(30);                       // cyc 45
    btn_in = 1'b1;
    exp_lvl(1'b0, 51);
    tick(12);                       // cyc 57

    // Glitch: 3 pressed cycles never reach the 4th sample; no events.
    btn_in = 1'b0;
    tick(3);                        // cyc 60
    btn_in = 1'b1;
    tick(12);                       // cyc 72

    // Bounce: toggle every cycle for 10 cycles, last toggle to 0 at 82.
    for (int i = 0; i < 10; i++) begin
      btn_in = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    btn_in = 1'b0;                  // cyc 82
    exp_lvl(1'b1, 88);
    exp_req(1'b1, 89);
    exp_req(1'b0, 92);
    tick(20);                       // cyc 102
    btn_in = 1'b1;
    exp_lvl(1'b0, 108);
    tick(12);                       // cyc 114

    // Repeat press: press, release 10, press again.
    btn_in = 1'b0;
    exp_lvl(1'b1, 120);
    exp_req(1'b1, 121);
    exp_req(1'b0, 124);
    tick(10);                       // cyc 124
    btn_in = 1'b1;
    exp_lvl(1'b0, 130);
    tick(10);                       // cyc 134
    btn_in = 1'b0;
    exp_lvl(1'b1, 140);
    exp_req(1'b1, 141);
    exp_req(1'b0, 144);
    tick(10);                       // cyc 144
    btn_in = 1'b1;
    exp_lvl(1'b0, 150);
    tick(12);                       // cyc 156

    // Reset mid-pulse: press at 156, pulse starts 163; reset at 164 for 2.
    btn_in = 1'b0;
    exp_lvl(1'b1, 162);
    exp_req(1'b1, 163);
    tick(8);                        // cyc 164 (2nd pulse cycle)
    reset_n = 1'b0;
    exp_lvl(1'b0, 164);             // async clear, reset_req stays 1
    tick(2);                        // cyc 166
    reset_n = 1'b1;
    exp_req(1'b0, 169);             // full 3-cycle pulse after release
    exp_lvl(1'b1, 172);             // button still held: re-debounced
    exp_req(1'b1, 173);             // FSM already back in IDLE
    exp_req(1'b0, 176);
    tick(14);                       // cyc 180
    btn_in = 1'b1;
    exp_lvl(1'b0, 186);
    tick(10);                       // cyc 190
    done = 1'b1;
  end

  // Monitor: every output change pops the next expected event for that
  // output; while reset is asserted the reset values are checked directly.
  always @(negedge clk) begin
    ev_t e;
    if (reset_n === 1'b0) begin
      n_checks++;
      if (reset_req !== 1'b1 || btn_level !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: cycle %0d got reset_req=%b btn_level=%b, need reset_req=1 btn_level=0",
                 cyc, reset_req, btn_level);
      end
    end
    if (reset_req !== prev_req) begin
      n_checks++;
      if (q_req.size() == 0) begin
        n_fail++;
        $display("FAIL reset_req_event: unexpected change to %b at cycle %0d", reset_req, cyc);
      end else begin
        e = q_req.pop_front();
        if (reset_req !== e.val || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL reset_req_event: got %b at cycle %0d, need %b at cycle %0d",
                   reset_req, cyc, e.val, e.cyc);
        end
      end
      prev_req = reset_req;
    end
    if (btn_level !== prev_lvl) begin
      n_checks++;
      if (q_lvl.size() == 0) begin
        n_fail++;
        $display("FAIL btn_level_event: unexpected change to %b at cycle %0d", btn_level, cyc);
      end else begin
        e = q_lvl.pop_front();
        if (btn_level !== e.val || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL btn_level_event: got %b at cycle %0d, need %b at cycle %0d",
                   btn_level, cyc, e.val, e.cyc);
        end
      end
      prev_lvl = btn_level;
    end
    if (done) begin
      n_checks++;
      if (q_req.size() != 0) begin
        n_fail++;
        $display("FAIL reset_req_missing: %0d expected changes never seen, need 0", q_req.size());
      end
      n_checks++;
      if (q_lvl.size() != 0) begin
        n_fail++;
        $display("FAIL btn_level_missing: %0d expected changes never seen, need 0", q_lvl.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish by 100000ns");
    $fatal(1);
  end

endmodule

// File: doc/reset_button_debounce.md
# reset_button_debounce

Conditions the raw board reset pushbutton into a clean, fixed-width active-high reset request. The request feeds the reset input of the power-on reset generator, which stretches and synchronously releases the system reset. The block synchronizes the asynchronous button, debounces it with a consecutive-sample counter and emits exactly one pulse per debounced press. It also emits a pulse after its own reset is released.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronized samples required to accept a level change. Minimum 2. Counter width is clog2(DEBOUNCE_CYCLES).
- PULSE_CYCLES, 16: width in clk cycles of each reset_req pulse. Minimum 1.
- BTN_ACTIVE_LOW, 1: 1 means the button pin reads 0 when pressed; 0 means it reads 1 when pressed.
- clk, input, 1: single clock. All state is in this domain.
- reset_n, input, 1: asynchronous, active-low reset. Asserts asynchronously; release is assumed synchronous to clk upstream.
- btn_in, input, 1: raw pushbutton pin. Asynchronous to clk and may bounce.
- reset_req, output, 1: active-high reset request, registered, to the power-on reset generator reset input.
- btn_level, output, 1: debounced press level, registered. 1 means pressed.

## Operation
- Synchronizer: 2 flops on btn_in, then polarity normalization. The result is btn_sync, with 1 meaning pressed. Both flops reset to the not-pressed level.
- Debounce:
  - If btn_sync equals btn_level, cnt is cleared to 0.
  - If they differ and cnt equals DEBOUNCE_CYCLES-1, btn_level takes btn_sync and cnt is cleared to 0.
  - Otherwise cnt increments.
  - Any agreeing sample clears cnt, so a change requires DEBOUNCE_CYCLES consecutive differing samples.
- FSM states are IDLE, PULSE and HOLD. pcnt is the pulse counter.
  - IDLE: if btn_level is 1, go to PULSE with pcnt=0.
  - PULSE: reset_req=1. pcnt increments each cycle. When pcnt equals PULSE_CYCLES-1, go to HOLD if btn_level is 1, otherwise go to IDLE.
  - HOLD: reset_req=0. When btn_level is 0, go to IDLE. A held button produces exactly one pulse.
- reset_req is registered and is 1 only in PULSE. The pulse width is independent of how long the button is held.
- Reset (reset_n=0), asynchronously:
  - Synchronizer flops are set to not-pressed, btn_level=0 and cnt=0.
  - State goes to PULSE with pcnt=0, so reset_req=1 immediately.
  - After release, reset_req stays 1 for exactly PULSE_CYCLES more rising edges, then the FSM enters IDLE with btn_level=0.
- reset_n asserted mid-PULSE or mid-HOLD: the block returns to the reset state above and a full PULSE_CYCLES pulse follows release.
- A press still debouncing when PULSE ends is not lost. btn_level rises later and IDLE then starts a new pulse.

## Timing
- Press latency: btn_in changes before edge 1.
  - btn_sync changes at edge 2.
  - btn_level changes at edge DEBOUNCE_CYCLES+2.
  - reset_req rises at edge DEBOUNCE_CYCLES+3.
- reset_req high for exactly PULSE_CYCLES cycles per pulse.
- Release latency: btn_level falls DEBOUNCE_CYCLES+2 edges after a clean release. HOLD to IDLE takes one further edge.
- Minimum press-to-press spacing for two pulses: release debounce, plus a return to IDLE, plus a new press debounce.
- Reset values: reset_req=1, btn_level=0.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, BTN_ACTIVE_LOW=1. btn_in idles at 1.
- Power-up: hold reset_n=0 for 5 cycles, then release -> reset_req=1 during reset and for 3 edges after release, then 0; btn_level=0 throughout.
- Clean press: btn_in goes 1→0 before edge 1 and is held for 30 cycles -> btn_level=1 at edge 6; reset_req=1 at edges 7–9 and 0 from edge 10; no second pulse while held (HOLD).
- Glitch rejection: btn_in=0 for 3 cycles, then back to 1 -> btn_level stays 0 and reset_req stays 0.
- Bounce: btn_in toggles every cycle for 10 cycles, then stays 0 -> exactly one btn_level rise, 6 edges after the last toggle; exactly one 3-cycle reset_req pulse.
- Repeat press: press, release for 10 cycles, press again -> btn_level falls 6 edges after release; two separate 3-cycle pulses.
- Reset mid-pulse: assert reset_n=0 at the 2nd pulse cycle for 2 cycles -> reset_req stays 1, then a full 3 cycles after release; btn_level=0 after reset even if btn_in is still 0, and it re-rises 6 edges later without a pulse until a return to IDLE.
